serial_subtractor: RTL and testbench

Bit-serial, multi-cycle subtractor computing `{bo, d} = a - b - bi`. It is the inverse counterpart of the team's combinational carry-out adder (`{c, o} = a + b + ci`). Operands are latched on a `start` pulse and processed LSB-first, one bit per clock, through a 1-bit full-subtractor cell. It sits beside the adder in the arithmetic library and serves area-constrained datapaths that can afford `WIDTH`-cycle latency.

---
 rtl/serial_subtractor_pkg.sv | 20 ++
 rtl/serial_subtractor_if.sv | 39 +++
 rtl/serial_subtractor_cell.sv | 13 +
 rtl/serial_subtractor.sv | 103 ++++++++++
 tb/tb_serial_subtractor.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Optional feature macro used by this slice: SERIAL_SUB_OVF_EN (signed overflow output).
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } sub_state_t;

    // Bit counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
// Carries the ov signal only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_OVF_EN
    logic             ov;

    modport master (
        output start, a, b, bi,
        input  d, bo, busy, done, ov
    );

    modport slave (
        input  start, a, b, bi,
        output d, bo, busy, done, ov
    );
`else
    modport master (
        output start, a, b, bi,
        input  d, bo, busy, done
    );

    modport slave (
        input  start, a, b, bi,
        output d, bo, busy, done
    );
`endif

endinterface

// File: rtl/serial_subtractor_cell.sv
// Combinational 1-bit full subtractor: {bout, d} = a - b - bin.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor {bo, d} = a - b - bi, LSB first, one bit per clock.
// Optional signed-overflow output ov is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    if (WIDTH < 2) begin : g_width_check
        $error("serial_subtractor: WIDTH must be at least 2");
    end

    sub_state_t       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_next;
    logic             brw;
    logic [CNT_W-1:0] cnt;
    logic             cell_d;
    logic             cell_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // res keeps only the upper WIDTH-1 collected bits; the full word is res_next on the last bit.
    assign res_next = {cell_d, res};

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            bus.d  <= '0;
            bus.bo <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            bus.ov <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        brw   <= bus.bi;
                        res   <= '0;
                        cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= bus.a[WIDTH-1];
                        b_msb <= bus.b[WIDTH-1];
`endif
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    brw  <= cell_bout;
                    res  <= res_next[WIDTH-1:1];
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        bus.d  <= res_next;
                        bus.bo <= cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                        bus.ov <= (a_msb ^ b_msb) & (cell_d ^ a_msb);
`endif
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8.
// Build with +define+SERIAL_SUB_OVF_EN to also check ov.
module tb_serial_subtractor;

    typedef struct {
        int d;
        int bo;
        int ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int done4_cnt = 0;
    int done8_cnt = 0;
    int last_done4 = -1;
    bit held_mode = 1'b0;

    exp_t q4[$];
    exp_t q8[$];

    serial_subtractor_if #(.WIDTH(4)) bus4 ();
    serial_subtractor_if #(.WIDTH(8)) bus8 ();

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: plain integer subtraction reduced modulo 2^w; ov from the sign-bit rule.
    function automatic exp_t ref_sub(input int w, input int a, input int b, input int bi);
        exp_t e;
        int m;
        int diff;
        m    = 1 << w;
        diff = a - b - bi;
        e.d  = (diff + m) % m;
        e.bo = (a < b + bi) ? 1 : 0;
        e.ov = (((a >> (w - 1)) & 1) != ((b >> (w - 1)) & 1) &&
                ((e.d >> (w - 1)) & 1) != ((a >> (w - 1)) & 1)) ? 1 : 0;
        return e;
    endfunction

    function automatic exp_t mk(input int d, input int bo, input int ov);
        exp_t e;
        e.d  = d;
        e.bo = bo;
        e.ov = ov;
        return e;
    endfunction

    task automatic wait_idle(input int w);
        int n;
        bit idle;
        n = 0;
        idle = (w == 4) ? (!bus4.busy && !bus4.done) : (!bus8.busy && !bus8.done);
        while (!idle && n < 40) begin
            @(posedge clk); #1;
            n++;
            idle = (w == 4) ? (!bus4.busy && !bus4.done) : (!bus8.busy && !bus8.done);
        end
        if (!idle) check("idle_wait", int'(idle), 1);
    endtask

    task automatic issue(input int w, input int a, input int b, input int bi, input exp_t e);
        wait_idle(w);
        if (w == 4) begin
            bus4.a = 4'(a); bus4.b = 4'(b); bus4.bi = bi[0]; bus4.start = 1'b1;
            q4.push_back(e);
        end else begin
            bus8.a = 8'(a); bus8.b = 8'(b); bus8.bi = bi[0]; bus8.start = 1'b1;
            q8.push_back(e);
        end
        @(posedge clk); #1;
        bus4.start = 1'b0;
        bus8.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (q4.size() != 0) check("drain4", q4.size(), 0);
        if (q8.size() != 0) check("drain8", q8.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus4.done) begin
                done4_cnt++;
                check("busy_done_excl4", int'(bus4.busy), 0);
                if (held_mode) begin
                    if (last_done4 >= 0) check("done_interval", cyc - last_done4, 6);
                    last_done4 = cyc;
                end
                check("done4_expected", (q4.size() > 0) ? 1 : 0, 1);
                if (q4.size() > 0) begin
                    e = q4.pop_front();
                    check("d4", int'(bus4.d), e.d);
                    check("bo4", int'(bus4.bo), e.bo);
`ifdef SERIAL_SUB_OVF_EN
                    check("ov4", int'(bus4.ov), e.ov);
`endif
                end
            end
            if (bus8.done) begin
                done8_cnt++;
                check("busy_done_excl8", int'(bus8.busy), 0);
                check("done8_expected", (q8.size() > 0) ? 1 : 0, 1);
                if (q8.size() > 0) begin
                    e = q8.pop_front();
                    check("d8", int'(bus8.d), e.d);
                    check("bo8", int'(bus8.bo), e.bo);
`ifdef SERIAL_SUB_OVF_EN
                    check("ov8", int'(bus8.ov), e.ov);
`endif
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 500000)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, off, idx, base;
        int ra, rb, rbi;

        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bi = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bi = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_busy", int'(bus4.busy), 0);
        check("rst_done", int'(bus4.done), 0);
        check("rst_d", int'(bus4.d), 0);
        check("rst_bo", int'(bus4.bo), 0);
        check("rst_d8", int'(bus8.d), 0);

        // Directed cases; ov follows the sign-bit rule.
        issue(4, 'hA, 'h5, 1, mk('h4, 0, 1));
        issue(4, 'h5, 'hA, 0, mk('hB, 1, 1));
        issue(4, 'h0, 'h0, 1, mk('hF, 1, 0));
        issue(4, 'h8, 'h1, 0, mk('h7, 0, 1));
        issue(4, 'hF, 'hF, 0, mk('h0, 0, 0));
        issue(8, 'h00, 'hFF, 1, mk('h00, 1, 0));
        issue(8, 'h80, 'h01, 0, mk('h7F, 0, 1));
        issue(8, 'hC3, 'h42, 1, mk('h80, 0, 0));
        drain();

        // Exhaustive 4-bit space in a random order (odd stride is a permutation mod 512).
        k   = int'(($urandom % 256) * 2 + 1);
        off = int'($urandom % 512);
        for (int i = 0; i < 512; i++) begin
            idx = (i * k + off) % 512;
            issue(4, idx & 15, (idx >> 4) & 15, (idx >> 8) & 1,
                  ref_sub(4, idx & 15, (idx >> 4) & 15, (idx >> 8) & 1));
        end
        for (int i = 0; i < 40; i++) begin
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            rbi = int'($urandom_range(0, 1));
            issue(8, ra, rb, rbi, ref_sub(8, ra, rb, rbi));
        end
        drain();

        // start held high: accepted every WIDTH+2 cycles, operands changing each cycle.
        wait_idle(4);
        base = done4_cnt;
        last_done4 = -1;
        held_mode = 1'b1;
        for (int c = 0; c < 24; c++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            rbi = int'($urandom_range(0, 1));
            bus4.a = 4'(ra); bus4.b = 4'(rb); bus4.bi = rbi[0]; bus4.start = 1'b1;
            if (c % 6 == 0) q4.push_back(ref_sub(4, ra, rb, rbi));
            @(posedge clk); #1;
        end
        bus4.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 held_mode = 1'b0;
        check("held_done_count", done4_cnt - base, 4);
        drain();

        // Reset sampled at the third SHIFT edge aborts without a done pulse.
        issue(4, 'hA, 'h5, 1, mk('h4, 0, 1));
        drain();
        wait_idle(4);
        bus4.a = 4'h7; bus4.b = 4'h2; bus4.bi = 1'b0; bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        base = done4_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", int'(bus4.busy), 0);
        check("abort_done", int'(bus4.done), 0);
        check("abort_d", int'(bus4.d), 0);
        check("abort_bo", int'(bus4.bo), 0);
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ov", int'(bus4.ov), 0);
`endif
        repeat (10) @(posedge clk);
        #1 check("abort_no_done", done4_cnt - base, 0);

        // Operation after abort works normally.
        issue(4, 'h3, 'h9, 1, ref_sub(4, 3, 9, 1));
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
